// File: rtl/bayes_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : bayes_stream_scheduler
// Description : Runs one stochastic Bayesian inference pass.
//               IDLE   - waits for start; latches stream_len and obs_en
//               FETCH  - reads one likelihood word per enabled observation
//                        through the mem_req/mem_obs/mem_ack/mem_data port
//               STREAM - for stream_len cycles, uses an LFSR to pick one bit
//                        of each stored word, ANDs the picked bits into
//                        bit_out and counts the ones in ones_count
//               DONE   - one-cycle done pulse, then back to IDLE
// Ports       : clk, rst (sync, active high)
//               start, stream_len, obs_en      run control
//               mem_req, mem_obs, mem_ack, mem_data  RRAM word readout
//               busy, bit_valid, bit_out, ones_count, done  status / result
// Revision    : 1.0 - initial release
// ============================================================================
module bayes_stream_scheduler #(
    parameter int M     = 8,
    parameter int N_OBS = 4,
    parameter int CNT_W = 8,
    parameter int IDX_W = (N_OBS > 1) ? $clog2(N_OBS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] stream_len,
    input  logic [N_OBS-1:0] obs_en,
    output logic             mem_req,
    output logic [IDX_W-1:0] mem_obs,
    input  logic             mem_ack,
    input  logic [M-1:0]     mem_data,
    output logic             busy,
    output logic             bit_valid,
    output logic             bit_out,
    output logic [CNT_W-1:0] ones_count,
    output logic             done
);

    localparam int          AW          = $clog2(M);
    localparam logic [15:0] c_lfsr_seed = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FETCH  = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_remain;
    logic [CNT_W-1:0] r_ones;
    logic [N_OBS-1:0] r_en;
    logic [IDX_W-1:0] r_idx;
    logic [M-1:0]     r_word [N_OBS];
    logic [15:0]      r_lfsr;
    logic             r_bit_valid;
    logic             r_bit_out;

    // Lowest enabled observation in the incoming mask, and the next enabled
    // observation above the one currently being fetched.
    logic [IDX_W-1:0] w_first_idx;
    logic [IDX_W-1:0] w_next_idx;
    logic             w_next_found;

    always_comb begin
        w_first_idx  = '0;
        w_next_idx   = r_idx;
        w_next_found = 1'b0;
        for (int i = N_OBS - 1; i >= 0; i--) begin
            if (obs_en[i]) begin
                w_first_idx = IDX_W'(i);
            end
            if (r_en[i] && (i > int'(r_idx))) begin
                w_next_idx   = IDX_W'(i);
                w_next_found = 1'b1;
            end
        end
    end

    // Each observation takes its own AW-bit slice of the LFSR as the bit
    // address; disabled observations pass a constant 1 into the AND.
    logic [N_OBS-1:0] w_pick;

    for (genvar g = 0; g < N_OBS; g++) begin : g_obs
        logic [AW-1:0] w_addr;
        assign w_addr    = r_lfsr[g*AW +: AW];
        assign w_pick[g] = r_en[g] ? r_word[g][w_addr] : 1'b1;
    end

    logic w_post;
    logic w_lfsr_fb;

    assign w_post    = &w_pick;
    // x^16 + x^14 + x^13 + x^11 + 1, shifting left into bit 0
    assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remain    <= '0;
            r_ones      <= '0;
            r_en        <= '0;
            r_idx       <= '0;
            r_lfsr      <= c_lfsr_seed;
            r_bit_valid <= 1'b0;
            r_bit_out   <= 1'b0;
            for (int i = 0; i < N_OBS; i++) begin
                r_word[i] <= '0;
            end
        end else begin
            r_bit_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remain <= stream_len;
                        r_en     <= obs_en;
                        r_ones   <= '0;
                        r_idx    <= w_first_idx;
                        if (obs_en != '0) begin
                            r_state <= S_FETCH;
                        end else if (stream_len != '0) begin
                            r_state <= S_STREAM;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_word[r_idx] <= mem_data;
                        if (w_next_found) begin
                            r_idx <= w_next_idx;
                        end else if (r_remain != '0) begin
                            r_state <= S_STREAM;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_STREAM: begin
                    r_bit_valid <= 1'b1;
                    r_bit_out   <= w_post;
                    r_ones      <= r_ones + {{(CNT_W-1){1'b0}}, w_post};
                    r_lfsr      <= {r_lfsr[14:0], w_lfsr_fb};
                    r_remain    <= r_remain - CNT_W'(1);
                    if (r_remain == CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req    = (r_state == S_FETCH);
    assign mem_obs    = r_idx;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign bit_valid  = r_bit_valid;
    assign bit_out    = r_bit_out;
    assign ones_count = r_ones;

endmodule
`default_nettype wire

// File: tb/tb_bayes_stream_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_bayes_stream_scheduler
// Description : Self-checking bench for bayes_stream_scheduler. A table of
//               directed runs, a batch of random runs and hand-written
//               sequences for start-during-fetch and reset-mid-stream are
//               compared against a behavioural model of the inference run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bayes_stream_scheduler;

    localparam int M     = 8;
    localparam int N_OBS = 4;
    localparam int CNT_W = 8;
    localparam int AW    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] stream_len;
    logic [N_OBS-1:0] obs_en;
    logic             mem_req;
    logic [1:0]       mem_obs;
    logic             mem_ack;
    logic [M-1:0]     mem_data;
    logic             busy;
    logic             bit_valid;
    logic             bit_out;
    logic [CNT_W-1:0] ones_count;
    logic             done;

    always #5 clk = ~clk;

    bayes_stream_scheduler #(.M(M), .N_OBS(N_OBS), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stream_len (stream_len),
        .obs_en     (obs_en),
        .mem_req    (mem_req),
        .mem_obs    (mem_obs),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .busy       (busy),
        .bit_valid  (bit_valid),
        .bit_out    (bit_out),
        .ones_count (ones_count),
        .done       (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- memory responder and output monitor ----------------
    logic [M-1:0] mem_words [N_OBS];
    int           ack_lat = 0;
    int           ack_cnt = 0;
    int           fetch_log[$];
    int           exp_bits[$];
    int           bits_seen = 0;
    int           done_seen = 0;
    int           done_ones = 0;
    int           done_bv   = 0;

    always @(negedge clk) begin
        if (rst) begin
            mem_ack = 1'b0;
            ack_cnt = 0;
        end else begin
            if (bit_valid) begin
                bits_seen++;
                if (exp_bits.size() > 0) check("bit_out", bit_out, exp_bits.pop_front());
                else                     check("extra bit_valid", bit_valid, 0);
            end
            if (done) begin
                done_seen++;
                done_ones = ones_count;
                done_bv   = bit_valid;
            end
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (ack_cnt >= ack_lat) begin
                    mem_ack  = 1'b1;
                    mem_data = mem_words[mem_obs];
                    fetch_log.push_back(int'(mem_obs));
                    ack_cnt  = 0;
                end else begin
                    ack_cnt++;
                end
            end
        end
    end

    // ---------------- behavioural reference model ----------------
    logic [15:0] model_lfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int   taps [4];
        logic fb;
        taps = '{16, 14, 13, 11};
        fb   = 1'b0;
        for (int k = 0; k < 4; k++) fb ^= s[taps[k]-1];
        return {s[14:0], fb};
    endfunction

    // Generates the expected bit stream for one run and returns its ones count.
    function automatic int model_run(input logic [3:0] en, input int len);
        int ones;
        int p;
        int a;
        ones = 0;
        for (int c = 0; c < len; c++) begin
            p = 1;
            for (int i = 0; i < N_OBS; i++) begin
                if (en[i]) begin
                    a = int'((model_lfsr >> (i * AW)) & 16'h7);
                    if (mem_words[i][a] == 1'b0) p = 0;
                end
            end
            exp_bits.push_back(p);
            ones += p;
            model_lfsr = lfsr_step(model_lfsr);
        end
        return ones;
    endfunction

    // ---------------- run helpers ----------------
    task automatic start_run(input logic [3:0] en, input int len);
        bits_seen = 0;
        done_seen = 0;
        fetch_log.delete();
        @(posedge clk); #1;
        obs_en     = en;
        stream_len = len[7:0];
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy after start", busy, 1);
    endtask

    task automatic finish_run(input logic [3:0] en, input int len, input int exp_ones);
        int k;
        for (int c = 0; c < 3000 && done_seen == 0; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("done pulse count", done_seen, 1);
        check("ones_count at done", done_ones, exp_ones);
        check("bit_valid with done", done_bv, (len != 0));
        check("bit_valid count", bits_seen, len);
        check("fetch count", fetch_log.size(), $countones(en));
        k = 0;
        for (int i = 0; i < N_OBS; i++) begin
            if (en[i]) begin
                if (k < fetch_log.size()) check("fetch order", fetch_log[k], i);
                k++;
            end
        end
        check("busy after done", busy, 0);
        check("ones_count hold", ones_count, exp_ones);
        check("expected bits left", exp_bits.size(), 0);
    endtask

    task automatic full_run(input logic [3:0] en, input int len, input int lat, input int exp_ones);
        int m;
        ack_lat = lat;
        exp_bits.delete();
        m = model_run(en, len);
        start_run(en, len);
        finish_run(en, len, (exp_ones < 0) ? m : exp_ones);
    endtask

    typedef struct {
        logic [7:0] w0, w1, w2, w3;
        logic [3:0] en;
        int         len;
        int         lat;
        int         exp_ones;   // -1: take the model result
    } vec_t;

    vec_t tbl [7];

    initial begin
        rst = 1'b1; start = 1'b0; stream_len = '0; obs_en = '0;
        mem_ack = 1'b0; mem_data = '0;
        model_lfsr = 16'hACE1;

        tbl[0] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'hF, 20,  0, 20};
        tbl[1] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 4'hF, 50,  0, 0};
        tbl[2] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 4'hB, 50,  1, 50};
        tbl[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 4'h0, 7,   0, 7};
        tbl[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 4'h1, 0,   2, 0};
        tbl[5] = '{8'h0F, 8'h00, 8'h00, 8'h00, 4'h1, 255, 0, -1};
        tbl[6] = '{8'h0F, 8'h00, 8'h00, 8'h00, 4'h1, 255, 1, -1};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset busy", busy, 0);
        check("reset mem_req", mem_req, 0);
        check("reset bit_valid", bit_valid, 0);
        check("reset bit_out", bit_out, 0);
        check("reset done", done, 0);
        check("reset ones_count", ones_count, 0);
        check("reset mem_obs", mem_obs, 0);

        // Directed table
        for (int t = 0; t < 7; t++) begin
            mem_words[0] = tbl[t].w0;
            mem_words[1] = tbl[t].w1;
            mem_words[2] = tbl[t].w2;
            mem_words[3] = tbl[t].w3;
            full_run(tbl[t].en, tbl[t].len, tbl[t].lat, tbl[t].exp_ones);
        end

        // Random runs against the model
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N_OBS; i++) mem_words[i] = 8'($urandom);
            full_run(4'($urandom), int'($urandom_range(0, 40)), int'($urandom_range(0, 2)), -1);
        end

        // start pulsed during FETCH must not disturb the run
        for (int i = 0; i < N_OBS; i++) mem_words[i] = 8'($urandom) | 8'h81;
        ack_lat = 3;
        exp_bits.delete();
        begin
            int m;
            m = model_run(4'hF, 10);
            start_run(4'hF, 10);
            @(posedge clk); #1;
            check("mem_req in fetch", mem_req, 1);
            stream_len = 8'd99;
            obs_en     = 4'h1;
            start      = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            finish_run(4'hF, 10, m);
        end

        // reset in the middle of STREAM
        for (int i = 0; i < N_OBS; i++) mem_words[i] = 8'($urandom);
        ack_lat = 0;
        exp_bits.delete();
        begin
            int m;
            m = model_run(4'h3, 100);
            start_run(4'h3, 100);
            for (int c = 0; c < 300 && bits_seen < 5; c++) @(posedge clk);
            #1;
            check("reached stream", (bits_seen >= 5), 1);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            exp_bits.delete();
            model_lfsr = 16'hACE1;
            check("abort busy", busy, 0);
            check("abort bit_valid", bit_valid, 0);
            check("abort ones_count", ones_count, 0);
            check("abort done", done, 0);
            check("abort mem_req", mem_req, 0);
            repeat (3) @(posedge clk);
            #1;
            check("no done after abort", done_seen, 0);
        end

        // LFSR restarts from the seed after reset
        mem_words[0] = 8'h5A;
        full_run(4'h1, 30, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bayes_stream_scheduler.md
Name: bayes_stream_scheduler

Overview:
Sequences one stochastic Bayesian inference run over a likelihood array.
- Fetches one M-bit likelihood word per enabled observation from the RRAM read port.
- For stream_len cycles, draws a pseudo-random bit address per observation and picks that bit from each stored word.
- ANDs the picked bits into a posterior stochastic bit and counts the ones.
- Sits between the top-level run control and the RRAM word readout; replaces per-observation address/select steering.

Parameters:
M, 8, likelihood word width (bits per RRAM row); power of two, >=2
N_OBS, 4, number of observations (word registers); N_OBS*$clog2(M) <= 16
CNT_W, 8, width of stream_len and ones_count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle run request, sampled only in IDLE
stream_len  in  CNT_W  number of stochastic cycles, sampled on accepted start
obs_en  in  N_OBS  observation enable mask, sampled on accepted start; disabled obs contribute constant 1
mem_req  out  1  read request for word mem_obs
mem_obs  out  max(1,$clog2(N_OBS))  observation index being fetched
mem_ack  in  1  read complete; mem_data valid this cycle
mem_data  in  M  likelihood word
busy  out  1  high from the cycle after an accepted start through the DONE cycle
bit_valid  out  1  bit_out valid this cycle
bit_out  out  1  posterior stochastic bit
ones_count  out  CNT_W  running count of bit_out==1 in the current run
done  out  1  one-cycle run-complete pulse

Behaviour:
- Reset: state IDLE. busy, mem_req, bit_valid, bit_out, done = 0. ones_count = 0, mem_obs = 0, word registers = 0. LFSR = 16'hACE1.
- Reset mid-run aborts immediately to the reset state. No done pulse is issued.
- State IDLE:
  - On start: latch stream_len and obs_en, clear ones_count, set idx to the first enabled obs, go to FETCH.
  - If obs_en == 0, go directly to STREAM (or to DONE if stream_len == 0).
- State FETCH:
  - mem_req = 1 and mem_obs = idx, both combinational from state/idx.
  - On mem_ack: capture mem_data into word[idx], then advance idx to the next enabled obs.
  - After the last enabled obs is acked, go to STREAM; go to DONE instead if stream_len == 0.
  - mem_req may stay high across consecutive obs; the index changes on the cycle after each ack.
  - Acks arriving outside FETCH are ignored.
- State STREAM: lasts exactly stream_len cycles, tracked by an internal down-counter.
  - Each cycle, obs i uses address a_i = lfsr[i*$clog2(M) +: $clog2(M)].
  - p = AND over i of (obs_en[i] ? word[i][a_i] : 1).
  - On the next edge: bit_valid <= 1, bit_out <= p, ones_count <= ones_count + p, LFSR advances.
  - After the last STREAM cycle go to DONE.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts left with feedback into bit 0.
  - Advances only in STREAM cycles.
  - Reset only by rst; not reseeded by start.
- State DONE: one cycle. done = 1. This cycle coincides with the last bit_valid, and ones_count is final. Then go to IDLE.
- ones_count holds its value in IDLE until the next accepted start. It never exceeds stream_len, so no overflow.
- bit_valid is low in every cycle not immediately following a STREAM cycle.
- start while busy (or in the DONE cycle) is ignored.
- stream_len == 0: no bit_valid; done pulses once after the fetch phase with ones_count = 0.
- Latency: FETCH phase = sum of per-word ack latencies. First bit_valid appears 1 cycle after STREAM is entered.

Test Plan:
- All words 8'hFF, obs_en=4'hF, stream_len=20, mem_ack 1 cycle after each req:
  - 4 fetches with mem_obs 0,1,2,3.
  - 20 bit_valid pulses, all bit_out=1.
  - done coincident with the 20th bit_valid; ones_count=20.
- word[2]=8'h00, others 8'hFF, obs_en=4'hF, stream_len=50 -> ones_count=0. obs_en=4'hB on the same words -> ones_count=50, only obs 0,1,3 fetched.
- obs_en=0, stream_len=7 -> no mem_req; 7 bits of 1; ones_count=7; done.
- stream_len=0, obs_en=4'h1 -> one fetch, no bit_valid, single done pulse, ones_count=0.
- Single obs word 8'h0F, stream_len=255, LFSR from reset seed:
  - ones_count matches a reference model bit-exactly.
  - A second run continues the LFSR sequence and matches the model.
- rst asserted mid-STREAM, and start pulsed during FETCH:
  - Reset: outputs zero the next cycle, no done.
  - Start during FETCH: ignored; the run completes with the original stream_len.
